// File: rtl/parking_gate_if.sv
// Lane-request, passage-pulse and barrier-control bundle for the parking ramp arbiter.
// Plain level/pulse signals; no handshake, no backpressure.
interface parking_gate_if;
  logic       req_in;
  logic       req_out;
  logic       entering;
  logic       exiting;
  logic [6:0] count;
  logic       gate_open;
  logic       grant_in;
  logic       grant_out;
  logic       lot_full;
  logic       timeout;

  modport master (
    output req_in, req_out, entering, exiting, count,
    input  gate_open, grant_in, grant_out, lot_full, timeout
  );

  modport slave (
    input  req_in, req_out, entering, exiting, count,
    output gate_open, grant_in, grant_out, lot_full, timeout
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Single-lane barrier arbiter: one direction at a time, fair on ties, closes on passage or timeout.
// Latency: request-to-grant 2 edges after first sample, passage-to-close 1 edge; no backpressure.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 99,
  parameter int OPEN_CYCLES  = 500_000_000,
  parameter int CLEAR_CYCLES = 100_000_000,
  parameter int TW           = 29
) (
  input logic            clk,
  input logic            btnC,
  parking_gate_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, CLEAR} state_t;

  localparam logic [6:0]    CAP7       = 7'(CAPACITY);
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          last_in, last_in_nxt;   // 1: entry was served most recently
  logic          timeout_q, timeout_nxt;
  logic          lot_full_q;
  logic [1:0]    req_in_sync, req_out_sync;
  logic          elig_in, elig_out;

  assign elig_in  = req_in_sync[1] & (bus.count < CAP7);
  assign elig_out = req_out_sync[1];

  always_ff @(posedge clk) begin
    if (btnC) begin
      state        <= IDLE;
      timer        <= '0;
      last_in      <= 1'b0;
      timeout_q    <= 1'b0;
      lot_full_q   <= 1'b0;
      req_in_sync  <= 2'b00;
      req_out_sync <= 2'b00;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      last_in      <= last_in_nxt;
      timeout_q    <= timeout_nxt;
      lot_full_q   <= (bus.count >= CAP7);
      req_in_sync  <= {req_in_sync[0], bus.req_in};
      req_out_sync <= {req_out_sync[0], bus.req_out};
    end
  end

  always_comb begin
    state_nxt   = state;
    last_in_nxt = last_in;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, serve the direction that did not go last.
        if (elig_in && (!elig_out || !last_in))
          state_nxt = GRANT_IN;
        else if (elig_out)
          state_nxt = GRANT_OUT;
      end
      GRANT_IN: begin
        if (bus.entering) begin
          state_nxt   = CLEAR;
          last_in_nxt = 1'b1;
        end else if (timer == OPEN_LAST) begin
          state_nxt   = CLEAR;
          last_in_nxt = 1'b1;
          timeout_nxt = 1'b1;
        end
      end
      GRANT_OUT: begin
        if (bus.exiting) begin
          state_nxt   = CLEAR;
          last_in_nxt = 1'b0;
        end else if (timer == OPEN_LAST) begin
          state_nxt   = CLEAR;
          last_in_nxt = 1'b0;
          timeout_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (timer == CLEAR_LAST)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state || state == IDLE)
      timer_nxt = '0;
    else
      timer_nxt = timer + TW'(1);
  end

  assign bus.grant_in  = (state == GRANT_IN);
  assign bus.grant_out = (state == GRANT_OUT);
  assign bus.gate_open = (state == GRANT_IN) || (state == GRANT_OUT);
  assign bus.lot_full  = lot_full_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: cycle-by-cycle vector table plus timeout/collision sequences.
module tb_parking_gate_arbiter;

  localparam int CAP   = 3;
  localparam int OPEN  = 20;
  localparam int CLR   = 5;

  localparam logic [4:0] Z    = 5'b00000;  // {gate_open, grant_in, grant_out, lot_full, timeout}
  localparam logic [4:0] GIN  = 5'b11000;
  localparam logic [4:0] GOUT = 5'b10100;
  localparam logic [4:0] LF   = 5'b00010;

  typedef struct {
    logic       rst;
    logic       rin;
    logic       rout;
    logic       ent;
    logic       ext;
    logic [6:0] cnt;
    logic [4:0] exp;
  } vec_t;

  logic clk;
  logic btnC;
  int   errors;
  int   checks;
  vec_t vecs[$];

  parking_gate_if gif();

  parking_gate_arbiter #(
    .CAPACITY(CAP), .OPEN_CYCLES(OPEN), .CLEAR_CYCLES(CLR), .TW(8)
  ) dut (
    .clk  (clk),
    .btnC (btnC),
    .bus  (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic rin, input logic rout, input logic ent,
                   input logic ext, input logic [6:0] cnt, input logic [4:0] exp);
    vec_t t;
    t.rst = rst; t.rin = rin; t.rout = rout; t.ent = ent; t.ext = ext; t.cnt = cnt; t.exp = exp;
    vecs.push_back(t);
  endtask

  function automatic logic [4:0] outs();
    return {gif.gate_open, gif.grant_in, gif.grant_out, gif.lot_full, gif.timeout};
  endfunction

  task automatic drive(input logic rst, input logic rin, input logic rout, input logic ent,
                       input logic ext, input logic [6:0] cnt);
    btnC         = rst;
    gif.req_in   = rin;
    gif.req_out  = rout;
    gif.entering = ent;
    gif.exiting  = ext;
    gif.count    = cnt;
  endtask

  task automatic wait_open(input string name);
    for (int i = 0; i < 10 && !gif.gate_open; i++) step();
    chk(name, gif.gate_open, 1);
  endtask

  int open_len;
  int closed;

  initial begin
    errors = 0;
    checks = 0;
    drive(1, 0, 0, 0, 0, 0);

    // reset, tie to IN, alternation, reset mid-grant
    v(1,0,0,0,0,0,Z);
    v(0,1,1,0,0,0,Z); v(0,1,1,0,0,0,Z); v(0,1,1,0,0,0,GIN);
    v(0,1,1,1,0,0,Z);
    for (int i = 0; i < 5; i++) v(0,1,1,0,0,0,Z);
    v(0,1,1,0,0,0,GOUT);
    v(0,1,1,0,1,0,Z);
    for (int i = 0; i < 5; i++) v(0,1,1,0,0,0,Z);
    v(0,1,1,0,0,0,GIN);
    v(1,1,1,0,0,0,Z);
    v(0,1,1,0,0,0,Z); v(0,1,1,0,0,0,Z); v(0,1,1,0,0,0,GIN);
    // wrong-direction pulse during GRANT_OUT
    v(0,1,1,1,0,0,Z);
    for (int i = 0; i < 5; i++) v(0,1,1,0,0,0,Z);
    v(0,1,1,0,0,0,GOUT);
    v(0,1,1,1,0,0,GOUT);
    v(0,1,1,0,0,0,GOUT);
    v(0,1,1,0,1,0,Z);
    // full lot: entry blocked, exit still served, then entry after count drops
    for (int i = 0; i < 7; i++) v(0,1,0,0,0,3,LF);
    v(0,1,1,0,0,3,LF); v(0,1,1,0,0,3,LF); v(0,1,1,0,0,3,GOUT|LF);
    v(0,1,0,0,1,3,LF);
    for (int i = 0; i < 5; i++) v(0,1,0,0,0,2,Z);
    v(0,1,0,0,0,2,GIN);
    // reaching capacity mid-grant keeps the gate open
    v(0,1,0,0,0,3,GIN|LF);
    v(0,1,0,1,0,3,LF);
    v(1,0,0,0,0,0,Z);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rin, vecs[i].rout, vecs[i].ent, vecs[i].ext, vecs[i].cnt);
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      if (gif.grant_in && gif.grant_out) chk($sformatf("excl%0d", i), 1, 0);
    end

    // entry timeout: open for exactly OPEN cycles, one-cycle timeout, CLEAR+IDLE closed
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0);
    wait_open("to_open");
    open_len = 0;
    while (gif.gate_open && open_len < 50) begin
      open_len++;
      step();
    end
    chk("to_open_len", open_len, OPEN);
    chk("to_pulse", gif.timeout, 1);
    closed = 0;
    do begin
      closed++;
      step();
      if (closed == 1) chk("to_pulse_end", gif.timeout, 0);
    end while (!gif.gate_open && closed < 20);
    chk("to_closed_len", closed, CLR + 1);

    // passage in the last open cycle beats the timeout
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0);
    wait_open("col_open");
    for (int i = 0; i < OPEN - 1; i++) step();
    chk("col_still_open", gif.gate_open, 1);
    gif.entering = 1'b1;
    step();
    gif.entering = 1'b0;
    chk("col_closed", gif.gate_open, 0);
    chk("col_no_timeout", gif.timeout, 0);
    step();
    chk("col_no_timeout2", gif.timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Sequencing controller for the single-lane parking ramp. It arbitrates between an entry request and an exit request, opens the shared barrier for exactly one direction at a time, and closes it when the vehicle-detection logic reports a completed passage or a timeout expires. It sits between the lane request inputs, the vehicle-detection FSM (`entering`/`exiting` pulses) and the occupancy counter (`count`), and blocks entry when the lot is full.

## Interface
- `CAPACITY`, default 99: maximum occupancy; entry is granted only while `count < CAPACITY`.
- `OPEN_CYCLES`, default 500_000_000: barrier-open timeout, 5 s at 100 MHz.
- `CLEAR_CYCLES`, default 100_000_000: closed hold time after each grant, 1 s.
- `TW`, default 29: timer width; must satisfy 2^TW ≥ max(`OPEN_CYCLES`, `CLEAR_CYCLES`).

Ports:
- `clk` in 1: 100 MHz clock.
- `btnC` in 1: reset; synchronous, active-high.
- `req_in` in 1: vehicle waiting at the entry lane (level, asynchronous).
- `req_out` in 1: vehicle waiting at the exit lane (level, asynchronous).
- `entering` in 1: one-cycle pulse from vehicle detection; entry passage completed. `clk` domain.
- `exiting` in 1: one-cycle pulse; exit passage completed. `clk` domain.
- `count` in 7: current occupancy, 0..99.
- `gate_open` out 1: barrier actuator.
- `grant_in` out 1: entry-lane green light.
- `grant_out` out 1: exit-lane green light.
- `lot_full` out 1: registered flag, `count >= CAPACITY`.
- `timeout` out 1: one-cycle pulse when a grant expires without passage.

## Operation
- `req_in` and `req_out` each pass through a two-flop synchronizer (reset to 0).
- The FSM uses only the second synchronizer stage; `entering`, `exiting` and `count` are used directly.
- **Eligibility**
  - `elig_in = req_in_s & (count < CAPACITY)`.
  - `elig_out = req_out_s`. No empty-lot check; a car at the exit is always present.
- **States:** IDLE, GRANT_IN, GRANT_OUT, CLEAR.
- **IDLE**
  - If only `elig_in`: go to GRANT_IN. If only `elig_out`: go to GRANT_OUT.
  - If both: grant the direction opposite to `last_served`.
  - Timer cleared on exit from IDLE.
- **GRANT_IN** (`gate_open=1`, `grant_in=1`)
  - Timer increments every cycle.
  - `entering` pulse: go to CLEAR, set `last_served=IN`.
  - Otherwise, timer == `OPEN_CYCLES-1`: pulse `timeout`, go to CLEAR, set `last_served=IN`.
  - `exiting` is ignored in this state.
- **GRANT_OUT:** symmetric, using `exiting`; `entering` is ignored.
- **Passage vs. timeout:** if the passage pulse and the timeout arrive in the same cycle, the passage wins and `timeout` stays 0.
- **CLEAR** (all grants and `gate_open` = 0)
  - Timer counts from 0; at `CLEAR_CYCLES-1` go to IDLE.
  - Requests and passage pulses are ignored.
- **Grant stability:** a grant is never revoked by a `count` change; reaching CAPACITY during GRANT_IN does not close the gate.
- **Output encoding:** `grant_in`, `grant_out`, `gate_open` are decoded from the state register (Moore, glitch-free). `grant_in` and `grant_out` are mutually exclusive in every cycle.

## Timing
- **Reset:** `btnC` high at an edge forces, from any state on that edge:
  - state = IDLE, timer = 0, `last_served` = OUT (so the first tie goes to IN), synchronizers = 0.
  - all outputs = 0, including `lot_full` and `timeout`.
- **Request latency:** a request first sampled high at edge k produces a grant (and `gate_open`) high after edge k+2.
- **Passage latency:** a passage pulse high in cycle n deasserts `gate_open` after edge n+1.
- **Timeout:** with no passage pulse, `gate_open` stays high for exactly `OPEN_CYCLES` cycles. `timeout` is high in the first CLEAR cycle only.
- **CLEAR duration:** exactly `CLEAR_CYCLES` cycles. Minimum gap between consecutive grants is `CLEAR_CYCLES + 1` cycles (the extra cycle is IDLE).
- **`lot_full`:** follows `count` with one-cycle latency.
- **Arithmetic:** `count` is compared as unsigned 7-bit against `CAPACITY` truncated to 7 bits. The timer never wraps; it is cleared on every state entry.

## Test plan
Parameters for all scenarios: `CAPACITY=3`, `OPEN_CYCLES=20`, `CLEAR_CYCLES=5`.
1. **Reset.** Assert `btnC` mid-GRANT_IN → next cycle all outputs 0. Then raise `req_in` and `req_out` together → `grant_in` first (`last_served`=OUT after reset).
2. **Fairness.** Hold `req_in` and `req_out` high with a passage pulse each grant → grants alternate IN, OUT, IN, OUT. Each CLEAR lasts 5 cycles; `gate_open` is never high for both directions.
3. **Entry timeout.** `req_in` high, `count=0`, no `entering` → `gate_open` high exactly 20 cycles, then one-cycle `timeout`, then 5 closed cycles.
4. **Passage/timeout collision.** `entering` pulse in the 20th open cycle → CLEAR entered, `timeout` stays 0.
5. **Full lot.** `count=3`, `req_in` high → no grant and `lot_full=1`. Add `req_out` → `grant_out` after 3 edges. After the pulse, lower `count` to 2 → `grant_in` follows after CLEAR+IDLE.
6. **Wrong-direction pulse.** During GRANT_OUT, pulse `entering` → ignored, gate stays open. A later `exiting` pulse closes the gate 1 edge later.
